// File: rtl/tenkey_scan_if.sv
// Bus bundle between the ten-key pad conditioner and its consumer.
// sw_raw flows into the conditioner; the accepted-key code and status flow out.
interface tenkey_scan_if;
    logic [9:0] sw_raw;
    logic [9:0] tenkey;
    logic       key_valid;
    logic       multi_err;
    logic       busy;

    // Stimulus / consumer side: drives the switches, observes the key code.
    modport master (
        output sw_raw,
        input  tenkey,
        input  key_valid,
        input  multi_err,
        input  busy
    );

    // Conditioner side: samples the switches, produces the key code.
    modport slave (
        input  sw_raw,
        output tenkey,
        output key_valid,
        output multi_err,
        output busy
    );
endinterface

// File: rtl/tenkey_scan.sv
// Ten-key pad front end: two-flop synchroniser, debounce FSM and a
// one-cycle one-hot key pulse. Stable multi-key patterns are rejected with a
// one-cycle multi_err pulse. Only the second synchroniser stage feeds the FSM.
module tenkey_scan #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic          clk,
    input  logic          reset,
    tenkey_scan_if.slave  bus
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WAIT_PRESS = 3'd1;
    localparam logic [2:0] HELD       = 3'd2;
    localparam logic [2:0] WAIT_REL   = 3'd3;
    localparam logic [2:0] REJECT     = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // True when exactly one bit of the pattern is set.
    function automatic logic is_onehot(input logic [9:0] v);
        logic [9:0] v_minus_one;
        v_minus_one = v - 10'd1;
        return (v != 10'd0) && ((v & v_minus_one) == 10'd0);
    endfunction

    logic [9:0]       sync1_r;
    logic [9:0]       s_r;
    logic [9:0]       cand_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       state_r;
    logic [9:0]       tenkey_r;
    logic             key_valid_r;
    logic             multi_err_r;

    logic [9:0]       cand_s;
    logic [CNT_W-1:0] cnt_s;
    logic [2:0]       state_s;
    logic [9:0]       tenkey_s;
    logic             key_valid_s;
    logic             multi_err_s;

    // Two-flop synchroniser for the asynchronous, bouncy switch inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 10'd0;
            s_r     <= 10'd0;
        end else begin
            sync1_r <= bus.sw_raw;
            s_r     <= sync1_r;
        end
    end

    // Debounce FSM next-state and output-pulse decode; pulses default to clear.
    always_comb begin
        cand_s      = cand_r;
        cnt_s       = cnt_r;
        state_s     = state_r;
        tenkey_s    = 10'd0;
        key_valid_s = 1'b0;
        multi_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (s_r != 10'd0) begin
                    cand_s  = s_r;
                    cnt_s   = CNT_ONE;
                    state_s = WAIT_PRESS;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_PRESS: begin
                if (s_r == 10'd0) begin
                    state_s = IDLE;
                end else if (s_r != cand_r) begin
                    cand_s = s_r;
                    cnt_s  = CNT_ONE;
                end else if (cnt_r < CNT_LAST) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    if (is_onehot(cand_r)) begin
                        tenkey_s    = cand_r;
                        key_valid_s = 1'b1;
                        state_s     = HELD;
                    end else begin
                        multi_err_s = 1'b1;
                        state_s     = REJECT;
                    end
                end
            end
            HELD, REJECT: begin
                // Extra keys while held are ignored; only a full release matters.
                if (s_r == 10'd0) begin
                    cnt_s   = CNT_ONE;
                    state_s = WAIT_REL;
                end else begin
                    state_s = state_r;
                end
            end
            WAIT_REL: begin
                // Any key seen again is release bounce: go back without a pulse.
                if (s_r != 10'd0) begin
                    state_s = HELD;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, candidate/counter and registered output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cand_r      <= 10'd0;
            cnt_r       <= {CNT_W{1'b0}};
            tenkey_r    <= 10'd0;
            key_valid_r <= 1'b0;
            multi_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cand_r      <= cand_s;
            cnt_r       <= cnt_s;
            tenkey_r    <= tenkey_s;
            key_valid_r <= key_valid_s;
            multi_err_r <= multi_err_s;
        end
    end

    assign bus.tenkey    = tenkey_r;
    assign bus.key_valid = key_valid_r;
    assign bus.multi_err = multi_err_r;
    assign bus.busy      = (state_r != IDLE);

endmodule

// File: tb/tb_tenkey_scan.sv
// Directed bench for tenkey_scan: clean, bouncy, glitch, multi-key,
// release-bounce and reset-abort scenarios with hand-computed timing.
module tb_tenkey_scan;

    logic clk;
    logic reset;

    tenkey_scan_if bus ();

    tenkey_scan #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int cyc;
    int pulse_cnt;
    int first_cyc;
    int merr_cnt;
    int merr_cyc;
    int incoh;
    logic [9:0] keys [4];

    // Clear the pulse recorder before a scenario.
    task automatic clear_mon();
        pulse_cnt = 0;
        first_cyc = -1;
        merr_cnt  = 0;
        merr_cyc  = -1;
        for (int i = 0; i < 4; i++) keys[i] = 10'd0;
    endtask

    // Advance n clock edges, sampling 1 ns after each edge and recording pulses.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.key_valid === 1'b1) begin
                if (pulse_cnt < 4) keys[pulse_cnt] = bus.tenkey;
                if (pulse_cnt == 0) first_cyc = cyc;
                pulse_cnt++;
            end
            if (bus.multi_err === 1'b1) begin
                if (merr_cnt == 0) merr_cyc = cyc;
                merr_cnt++;
            end
            if ((bus.key_valid === 1'b1) !== (bus.tenkey !== 10'd0)) incoh++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.sw_raw = 10'd0;
        #1;
        checks++;
        if ({bus.tenkey, bus.key_valid, bus.multi_err, bus.busy} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {bus.tenkey, bus.key_valid, bus.multi_err, bus.busy});
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_clean_press();
        clear_mon();
        bus.sw_raw = 10'h008;
        cyc = 0;
        run(20);
        checks++;
        if (pulse_cnt !== 1) begin errors++; $display("FAIL clean_count: got %0d expected 1", pulse_cnt); end
        checks++;
        if (first_cyc !== 6) begin errors++; $display("FAIL clean_latency: got %0d expected 6", first_cyc); end
        checks++;
        if (keys[0] !== 10'h008) begin errors++; $display("FAIL clean_key: got %h expected 008", keys[0]); end
        bus.sw_raw = 10'd0;
        cyc = 0;
        run(5);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL clean_busy_hold: got %b expected 1", bus.busy); end
        run(1);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL clean_busy_idle: got %b expected 0", bus.busy); end
    endtask

    task automatic test_bouncy_press();
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            bus.sw_raw = ((i / 2) % 2 == 1) ? 10'h080 : 10'h000;
            run(1);
        end
        checks++;
        if (pulse_cnt !== 0) begin errors++; $display("FAIL bouncy_early: got %0d expected 0", pulse_cnt); end
        bus.sw_raw = 10'h080;
        cyc = 0;
        run(12);
        checks++;
        if (pulse_cnt !== 1 || first_cyc !== 6 || keys[0] !== 10'h080) begin
            errors++;
            $display("FAIL bouncy_pulse: got n=%0d cyc=%0d key=%h expected n=1 cyc=6 key=080",
                     pulse_cnt, first_cyc, keys[0]);
        end
        bus.sw_raw = 10'd0;
        run(8);
    endtask

    task automatic test_glitch();
        clear_mon();
        bus.sw_raw = 10'h001;
        run(2);
        bus.sw_raw = 10'd0;
        run(8);
        checks++;
        if (pulse_cnt !== 0 || merr_cnt !== 0) begin
            errors++;
            $display("FAIL glitch_pulses: got key=%0d err=%0d expected 0 0", pulse_cnt, merr_cnt);
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b expected 0", bus.busy); end
    endtask

    task automatic test_multi_key();
        clear_mon();
        bus.sw_raw = 10'h088;
        cyc = 0;
        run(10);
        checks++;
        if (merr_cnt !== 1 || merr_cyc !== 6) begin
            errors++;
            $display("FAIL multi_err_pulse: got n=%0d cyc=%0d expected n=1 cyc=6", merr_cnt, merr_cyc);
        end
        bus.sw_raw = 10'd0;
        run(10);
        checks++;
        if (pulse_cnt !== 0 || merr_cnt !== 1) begin
            errors++;
            $display("FAIL multi_after_release: got key=%0d err=%0d expected 0 1", pulse_cnt, merr_cnt);
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL multi_idle: got %b expected 0", bus.busy); end
    endtask

    task automatic test_release_bounce();
        clear_mon();
        bus.sw_raw = 10'h008;
        run(10);
        for (int i = 0; i < 6; i++) begin
            bus.sw_raw = (i % 2 == 0) ? 10'h000 : 10'h008;
            run(1);
        end
        bus.sw_raw = 10'd0;
        run(10);
        checks++;
        if (pulse_cnt !== 1 || keys[0] !== 10'h008) begin
            errors++;
            $display("FAIL release_bounce: got n=%0d key=%h expected n=1 key=008", pulse_cnt, keys[0]);
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL release_idle: got %b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid_press();
        clear_mon();
        bus.sw_raw = 10'h020;
        run(4);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL midpress_busy: got %b expected 1", bus.busy); end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.tenkey, bus.key_valid, bus.multi_err, bus.busy} !== 13'd0) begin
            errors++;
            $display("FAIL midpress_reset_out: got %h expected 0",
                     {bus.tenkey, bus.key_valid, bus.multi_err, bus.busy});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        run(10);
        checks++;
        if (pulse_cnt !== 1 || first_cyc !== 6 || keys[0] !== 10'h020) begin
            errors++;
            $display("FAIL midpress_repress: got n=%0d cyc=%0d key=%h expected n=1 cyc=6 key=020",
                     pulse_cnt, first_cyc, keys[0]);
        end
        bus.sw_raw = 10'd0;
        run(8);
    endtask

    task automatic test_back_to_back();
        clear_mon();
        bus.sw_raw = 10'h008;
        run(8);
        bus.sw_raw = 10'd0;
        run(8);
        bus.sw_raw = 10'h080;
        run(8);
        bus.sw_raw = 10'd0;
        run(8);
        checks++;
        if (pulse_cnt !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", pulse_cnt); end
        checks++;
        if (keys[0] !== 10'h008 || keys[1] !== 10'h080) begin
            errors++;
            $display("FAIL b2b_order: got %h,%h expected 008,080", keys[0], keys[1]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        incoh  = 0;
        bus.sw_raw = 10'd0;
        reset = 1'b1;
        clear_mon();
        test_reset();
        test_clean_press();
        test_bouncy_press();
        test_glitch();
        test_multi_key();
        test_release_bounce();
        test_reset_mid_press();
        test_back_to_back();
        checks++;
        if (incoh !== 0) begin errors++; $display("FAIL valid_coherence: got %0d expected 0", incoh); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
